// File: rtl/conv1d_pkg.sv
// Shared types and widths for the 1D convolution sequencer.
// WEIGHT_REUSE_EN (optional) keeps weights resident between jobs.
package conv1d_pkg;

  localparam int DATA_W = 14;
  localparam int ACC_W  = 28;

  typedef enum logic [2:0] {
    LOAD_W,
    LOAD_X,
    COMPUTE,
    DRAIN,
    OUT
  } state_e;

endpackage

// File: rtl/conv1d_ctrl_counter.sv
// Clear/enable up-counter used for the weight, sample, tap and output indices.
// Clear wins over enable; reset is synchronous and active-high.
module conv_counter
  import conv1d_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_d, q_q;

  always_comb begin
    q_d = q_q;
    if (clr_i) begin
      q_d = '0;
    end else if (en_i) begin
      q_d = q_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/conv1d_ctrl.sv
// Load-weights / load-samples / sweep sequencer driving the conv memories and MAC.
// Define WEIGHT_REUSE_EN to skip the weight load on jobs after the first.
module conv1d_ctrl
  import conv1d_pkg::*;
#(
  parameter int N        = 8,
  parameter int M        = 3,
  parameter int ADDR_X_W = (N > 1) ? $clog2(N) : 1,
  parameter int ADDR_W_W = (M > 1) ? $clog2(M) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                input_valid,
  output logic                input_ready,
  output logic                output_valid,
  input  logic                output_ready,
  output logic [ADDR_X_W-1:0] addr_x,
  output logic                wr_en_x,
  output logic [ADDR_W_W-1:0] addr_w,
  output logic                wr_en_w,
  output logic                clear_acc,
  output logic                en_acc
);

  localparam logic [ADDR_W_W-1:0] W_LAST = ADDR_W_W'(M - 1);
  localparam logic [ADDR_X_W-1:0] X_LAST = ADDR_X_W'(N - 1);
  localparam logic [ADDR_X_W-1:0] O_LAST = ADDR_X_W'(N - M);

  state_e state_q, state_d;
  logic   issue_q;

  logic [ADDR_W_W-1:0] wcnt, tap;
  logic [ADDR_X_W-1:0] xcnt, oidx;

  logic wcnt_clr, wcnt_en;
  logic xcnt_clr, xcnt_en;
  logic tap_clr, tap_en;
  logic oidx_clr, oidx_en;
  logic accept, hs;

  conv_counter #(.WIDTH(ADDR_W_W)) u_wcnt (
    .clk_i(clk), .rst_i(reset),
    .clr_i(wcnt_clr), .en_i(wcnt_en), .q_o(wcnt)
  );

  conv_counter #(.WIDTH(ADDR_X_W)) u_xcnt (
    .clk_i(clk), .rst_i(reset),
    .clr_i(xcnt_clr), .en_i(xcnt_en), .q_o(xcnt)
  );

  conv_counter #(.WIDTH(ADDR_W_W)) u_tap (
    .clk_i(clk), .rst_i(reset),
    .clr_i(tap_clr), .en_i(tap_en), .q_o(tap)
  );

  conv_counter #(.WIDTH(ADDR_X_W)) u_oidx (
    .clk_i(clk), .rst_i(reset),
    .clr_i(oidx_clr), .en_i(oidx_en), .q_o(oidx)
  );

  assign input_ready  = (state_q == LOAD_W) || (state_q == LOAD_X);
  assign output_valid = (state_q == OUT);
  assign accept       = input_valid && input_ready;
  assign hs           = output_valid && output_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LOAD_W;
      issue_q <= 1'b0;
    end else begin
      state_q <= state_d;
      issue_q <= (state_q == COMPUTE);
    end
  end

  // Read data lags the address by one cycle, so MAC enable trails issue.
  always_comb begin
    state_d   = state_q;
    clear_acc = 1'b0;
    en_acc    = 1'b0;
    wr_en_w   = 1'b0;
    wr_en_x   = 1'b0;
    addr_w    = tap;
    addr_x    = oidx + ADDR_X_W'(tap);
    wcnt_clr  = 1'b0;
    wcnt_en   = 1'b0;
    xcnt_clr  = 1'b0;
    xcnt_en   = 1'b0;
    tap_clr   = 1'b0;
    tap_en    = 1'b0;
    oidx_clr  = 1'b0;
    oidx_en   = 1'b0;
    unique case (state_q)
      LOAD_W: begin
        clear_acc = 1'b1;
        addr_w    = wcnt;
        addr_x    = xcnt;
        wr_en_w   = accept;
        wcnt_en   = accept;
        if (accept && (wcnt == W_LAST)) begin
          wcnt_clr = 1'b1;
          state_d  = LOAD_X;
        end
      end
      LOAD_X: begin
        clear_acc = 1'b1;
        addr_w    = '0;
        addr_x    = xcnt;
        wr_en_x   = accept;
        xcnt_en   = accept;
        if (accept && (xcnt == X_LAST)) begin
          xcnt_clr = 1'b1;
          oidx_clr = 1'b1;
          tap_clr  = 1'b1;
          state_d  = COMPUTE;
        end
      end
      COMPUTE: begin
        en_acc = issue_q;
        if (tap == W_LAST) begin
          state_d = DRAIN;
        end else begin
          tap_en = 1'b1;
        end
      end
      DRAIN: begin
        en_acc  = issue_q;
        state_d = OUT;
      end
      OUT: begin
        if (hs) begin
          clear_acc = 1'b1;
          if (oidx == O_LAST) begin
`ifdef WEIGHT_REUSE_EN
            state_d = LOAD_X;
`else
            state_d = LOAD_W;
`endif
          end else begin
            oidx_en = 1'b1;
            tap_clr = 1'b1;
            state_d = COMPUTE;
          end
        end
      end
      default: state_d = LOAD_W;
    endcase
  end

endmodule

// File: tb/tb_conv1d_ctrl.sv
// Directed bench: controller plus behavioural memories and MAC, M=3, N=8.
// Covers sweep timing, backpressure, upstream gaps, reset abort, weight reuse.
module tb_conv1d_ctrl;
  import conv1d_pkg::*;

  localparam int N   = 8;
  localparam int M   = 3;
  localparam int AXW = 3;
  localparam int AWW = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic input_valid = 1'b0;
  logic output_ready = 1'b1;
  logic input_ready, output_valid;
  logic wr_en_x, wr_en_w, clear_acc, en_acc;
  logic [AXW-1:0] addr_x;
  logic [AWW-1:0] addr_w;

  logic [DATA_W-1:0] input_data = '0;
  logic [DATA_W-1:0] wmem [4];
  logic [DATA_W-1:0] xmem [N];
  logic [DATA_W-1:0] wq = '0;
  logic [DATA_W-1:0] xq = '0;
  logic [ACC_W-1:0]  acc = '0;

  int cyc = 0;
  int nw = 0;
  int nx = 0;
  int checks = 0;
  int errors = 0;
  int rise = 0;
  int beat_cyc = 0;

  conv1d_ctrl #(.N(N), .M(M)) dut (
    .clk(clk), .reset(reset),
    .input_valid(input_valid), .input_ready(input_ready),
    .output_valid(output_valid), .output_ready(output_ready),
    .addr_x(addr_x), .wr_en_x(wr_en_x),
    .addr_w(addr_w), .wr_en_w(wr_en_w),
    .clear_acc(clear_acc), .en_acc(en_acc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (wr_en_w) begin
      wmem[addr_w] <= input_data;
      nw <= nw + 1;
    end
    if (wr_en_x) begin
      xmem[addr_x] <= input_data;
      nx <= nx + 1;
    end
    wq <= wmem[addr_w];
    xq <= xmem[addr_x];
    if (clear_acc) acc <= '0;
    else if (en_acc) acc <= acc + ACC_W'(wq) * ACC_W'(xq);
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic send(input int d, input bit gap);
    int n = 0;
    if (gap) @(negedge clk);
    @(negedge clk);
    input_valid = 1'b1;
    input_data  = DATA_W'(d);
    while (!input_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk("send_timeout", 0, 1);
    beat_cyc = cyc;
    @(posedge clk);
    #1 input_valid = 1'b0;
  endtask

  task automatic load_w(input int w0, input int w1, input int w2, input bit gaps);
    send(w0, 1'b0);
    send(w1, gaps);
    send(w2, 1'b0);
  endtask

  task automatic load_x(input int x0, input bit gaps);
    for (int i = 0; i < N; i++) send(x0 + i, gaps && i[0]);
  endtask

  task automatic get_out(input string tag, input int exp, input int hold, input int sweep);
    int n = 0;
    @(negedge clk);
    while (!output_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) begin
      chk({tag, "_timeout"}, 0, 1);
      return;
    end
    rise = cyc;
    chk(tag, int'(acc), exp);
    for (int i = 0; i < hold; i++) begin
      chk("bp_valid", int'(output_valid), 1);
      chk("bp_acc", int'(acc), exp);
      chk("bp_en", int'(en_acc), 0);
      chk("bp_clr", int'(clear_acc), 0);
      @(negedge clk);
    end
    output_ready = 1'b1;
    #1;
    chk("hs_clr", int'(clear_acc), 1);
    @(posedge clk);
    #1;
    if (sweep >= 0) begin
      for (int k = 0; k < 4; k++) begin
        if (k < 3) begin
          chk("sweep_aw", int'(addr_w), k);
          chk("sweep_ax", int'(addr_x), sweep + k);
        end
        chk("sweep_en", int'(en_acc), (k > 0) ? 1 : 0);
        if (k < 3) begin
          @(posedge clk);
          #1;
        end
      end
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got 0 exp 1");
    $fatal(1);
  end

  initial begin
    int prev;
    int w0;
    int x0;
    int ea [6];
    int eb [6];
    ea = '{14, 20, 26, 32, 38, 44};
    eb = '{6, 9, 12, 15, 18, 21};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", int'(input_ready), 1);
    chk("rst_valid", int'(output_valid), 0);
    chk("rst_wrx", int'(wr_en_x), 0);
    chk("rst_wrw", int'(wr_en_w), 0);
    chk("rst_en", int'(en_acc), 0);
    chk("rst_clr", int'(clear_acc), 1);
    chk("rst_ax", int'(addr_x), 0);
    chk("rst_aw", int'(addr_w), 0);
    reset = 1'b0;

    // Job A: basic run with address sweep and spacing
    w0 = nw;
    x0 = nx;
    load_w(1, 2, 3, 1'b0);
    load_x(1, 1'b0);
    chk("a_nw", nw - w0, 3);
    chk("a_nx", nx - x0, 8);
    prev = 0;
    for (int i = 0; i < 6; i++) begin
      get_out("a_out", ea[i], 0, (i == 1) ? 2 : -1);
      if (i == 0) chk("latency", rise - beat_cyc, M + 2);
      else chk("spacing", rise - prev, M + 2);
      prev = rise;
    end
    chk("a_done_ready", int'(input_ready), 1);
    chk("a_done_valid", int'(output_valid), 0);

`ifdef WEIGHT_REUSE_EN
    w0 = nw;
    load_x(2, 1'b0);
    for (int i = 0; i < 6; i++) get_out("r_out", 20 + 6 * i, 0, -1);
    chk("r_no_wrw", nw - w0, 0);
    pulse_reset();
`endif

    // Job B: upstream gaps and output backpressure
    w0 = nw;
    x0 = nx;
    load_w(1, 2, 3, 1'b1);
    load_x(1, 1'b1);
    chk("b_nw", nw - w0, 3);
    chk("b_nx", nx - x0, 8);
    output_ready = 1'b0;
    get_out("b_out", ea[0], 7, -1);
    for (int i = 1; i < 6; i++) get_out("b_out", ea[i], 0, -1);

`ifdef WEIGHT_REUSE_EN
    pulse_reset();
`endif

    // Job C: abort in the middle of output 3, then a fresh job
    load_w(1, 2, 3, 1'b0);
    load_x(1, 1'b0);
    for (int i = 0; i < 3; i++) get_out("c_out", ea[i], 0, -1);
    @(posedge clk);
    #1;
    pulse_reset();
    @(negedge clk);
    chk("abort_valid", int'(output_valid), 0);
    chk("abort_ready", int'(input_ready), 1);
    chk("abort_en", int'(en_acc), 0);
    chk("abort_clr", int'(clear_acc), 1);
    load_w(1, 1, 1, 1'b0);
    load_x(1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      get_out("c2_out", eb[i], 0, -1);
      if (i == 0) chk("c2_latency", rise - beat_cyc, M + 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
